// File: rtl/chi_rn_pkg.sv
// Shared definitions for the CHI request-node engine: request opcodes and slot states.
`timescale 1ns/1ps
package chi_rn_pkg;

    localparam logic [3:0] CHI_OP_READ  = 4'b0001;
    localparam logic [3:0] CHI_OP_WRITE = 4'b0010;

    typedef enum logic [1:0] {
        FREE,
        ALLOC,
        OUTST
    } slot_state_t;

endpackage

// File: rtl/chi_rn_txn_tracker.sv
// Slot table for outstanding CHI transactions: slot state, write flag, response timers,
// lowest-free-slot allocation and single-winner completion arbitration.
`timescale 1ns/1ps
module chi_rn_txn_tracker
    import chi_rn_pkg::*;
#(
    parameter int unsigned NUM_TXN = 4,
    parameter int unsigned TXNID_W = $clog2(NUM_TXN),
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_alloc,
    input  logic               i_alloc_write,
    output logic               o_any_free,
    output logic [TXNID_W-1:0] o_free_idx,
    input  logic               i_issue,
    input  logic [TXNID_W-1:0] i_issue_idx,
    input  logic               i_rsp_valid,
    input  logic [TXNID_W-1:0] i_rsp_txnid,
    output logic               o_cpl_fire,
    output logic [TXNID_W-1:0] o_cpl_idx,
    output logic               o_cpl_err,
    output logic               o_cpl_write,
    output logic               o_spurious,
    output logic [TXNID_W:0]   o_outstanding
);

    localparam int unsigned TIMER_W = $clog2(TIMEOUT + 1);
    localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(TIMEOUT);

    slot_state_t        r_state [NUM_TXN];
    logic [TIMER_W-1:0] r_timer [NUM_TXN];
    logic [NUM_TXN-1:0] r_write;

    logic               w_any_free;
    logic [TXNID_W-1:0] w_free_idx;
    logic               w_any_to;
    logic [TXNID_W-1:0] w_to_idx;
    logic               w_rsp_hit;
    logic               w_cpl_fire;
    logic [TXNID_W-1:0] w_cpl_idx;
    logic [TXNID_W:0]   w_count;

    // Descending scans so the lowest matching index is the one left standing.
    always_comb begin
        w_any_free = 1'b0;
        w_free_idx = '0;
        w_any_to   = 1'b0;
        w_to_idx   = '0;
        w_count    = '0;
        for (int i = NUM_TXN - 1; i >= 0; i--) begin
            if (r_state[i] == FREE) begin
                w_any_free = 1'b1;
                w_free_idx = TXNID_W'(i);
            end
            if (r_state[i] == OUTST && r_timer[i] == TIMER_MAX) begin
                w_any_to = 1'b1;
                w_to_idx = TXNID_W'(i);
            end
            if (r_state[i] != FREE) begin
                w_count = w_count + (TXNID_W + 1)'(1);
            end
        end
    end

    // A matching response always beats any timeout, including one on the same slot.
    assign w_rsp_hit  = i_rsp_valid && (r_state[i_rsp_txnid] == OUTST);
    assign w_cpl_fire = w_rsp_hit || w_any_to;
    assign w_cpl_idx  = w_rsp_hit ? i_rsp_txnid : w_to_idx;

    assign o_any_free    = w_any_free;
    assign o_free_idx    = w_free_idx;
    assign o_cpl_fire    = w_cpl_fire;
    assign o_cpl_idx     = w_cpl_idx;
    assign o_cpl_err     = !w_rsp_hit;
    assign o_cpl_write   = r_write[w_cpl_idx];
    assign o_spurious    = i_rsp_valid && !w_rsp_hit;
    assign o_outstanding = w_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_TXN; i++) begin
                r_state[i] <= FREE;
                r_timer[i] <= '0;
            end
            r_write <= '0;
        end else begin
            for (int i = 0; i < NUM_TXN; i++) begin
                if (r_state[i] == OUTST && r_timer[i] != TIMER_MAX) begin
                    r_timer[i] <= r_timer[i] + TIMER_W'(1);
                end
                if (w_cpl_fire && w_cpl_idx == TXNID_W'(i)) begin
                    r_state[i] <= FREE;
                end
                if (i_issue && i_issue_idx == TXNID_W'(i)) begin
                    r_state[i] <= OUTST;
                    r_timer[i] <= '0;
                end
                if (i_alloc && w_free_idx == TXNID_W'(i)) begin
                    r_state[i] <= ALLOC;
                    r_write[i] <= i_alloc_write;
                end
            end
        end
    end

endmodule

// File: rtl/chi_rn_req_engine.sv
// Multi-outstanding CHI request-node engine: accepts master commands, issues them with a
// slot TXNID, and reports response or timeout completions back to the master.
`timescale 1ns/1ps
module chi_rn_req_engine
    import chi_rn_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned NUM_TXN = 4,
    parameter int unsigned TXNID_W = $clog2(NUM_TXN),
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_cmd_valid,
    output logic               o_cmd_ready,
    input  logic               i_cmd_write,
    input  logic [ADDR_W-1:0]  i_cmd_addr,
    input  logic [DATA_W-1:0]  i_cmd_wdata,
    output logic               o_req_valid,
    input  logic               i_req_ready,
    output logic [3:0]         o_req_opcode,
    output logic [ADDR_W-1:0]  o_req_addr,
    output logic [DATA_W-1:0]  o_req_wdata,
    output logic [TXNID_W-1:0] o_req_txnid,
    input  logic               i_rsp_valid,
    input  logic [TXNID_W-1:0] i_rsp_txnid,
    input  logic [DATA_W-1:0]  i_rsp_rdata,
    output logic               o_cpl_valid,
    output logic [TXNID_W-1:0] o_cpl_txnid,
    output logic               o_cpl_write,
    output logic [DATA_W-1:0]  o_cpl_rdata,
    output logic               o_cpl_err,
    output logic               o_err_spurious,
    output logic [TXNID_W:0]   o_outstanding
);

    logic               r_req_valid;
    logic [3:0]         r_req_opcode;
    logic [ADDR_W-1:0]  r_req_addr;
    logic [DATA_W-1:0]  r_req_wdata;
    logic [TXNID_W-1:0] r_req_txnid;

    logic               r_cpl_valid;
    logic [TXNID_W-1:0] r_cpl_txnid;
    logic               r_cpl_write;
    logic [DATA_W-1:0]  r_cpl_rdata;
    logic               r_cpl_err;
    logic               r_err_spurious;

    logic               w_any_free;
    logic [TXNID_W-1:0] w_free_idx;
    logic               w_accept;
    logic               w_handshake;
    logic               w_cpl_fire;
    logic [TXNID_W-1:0] w_cpl_idx;
    logic               w_cpl_err;
    logic               w_cpl_write;
    logic               w_spurious;

    // The request register may be reloaded in the same cycle its current beat is taken.
    assign o_cmd_ready = (!r_req_valid || i_req_ready) && w_any_free;
    assign w_accept    = i_cmd_valid && o_cmd_ready;
    assign w_handshake = r_req_valid && i_req_ready;

    chi_rn_txn_tracker #(
        .NUM_TXN (NUM_TXN),
        .TXNID_W (TXNID_W),
        .TIMEOUT (TIMEOUT)
    ) u_tracker (
        .clk           (clk),
        .reset         (reset),
        .i_alloc       (w_accept),
        .i_alloc_write (i_cmd_write),
        .o_any_free    (w_any_free),
        .o_free_idx    (w_free_idx),
        .i_issue       (w_handshake),
        .i_issue_idx   (r_req_txnid),
        .i_rsp_valid   (i_rsp_valid),
        .i_rsp_txnid   (i_rsp_txnid),
        .o_cpl_fire    (w_cpl_fire),
        .o_cpl_idx     (w_cpl_idx),
        .o_cpl_err     (w_cpl_err),
        .o_cpl_write   (w_cpl_write),
        .o_spurious    (w_spurious),
        .o_outstanding (o_outstanding)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_req_valid  <= 1'b0;
            r_req_opcode <= '0;
            r_req_addr   <= '0;
            r_req_wdata  <= '0;
            r_req_txnid  <= '0;
        end else if (w_accept) begin
            r_req_valid  <= 1'b1;
            r_req_opcode <= i_cmd_write ? CHI_OP_WRITE : CHI_OP_READ;
            r_req_addr   <= i_cmd_addr;
            r_req_wdata  <= i_cmd_write ? i_cmd_wdata : '0;
            r_req_txnid  <= w_free_idx;
        end else if (w_handshake) begin
            r_req_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cpl_valid    <= 1'b0;
            r_cpl_txnid    <= '0;
            r_cpl_write    <= 1'b0;
            r_cpl_rdata    <= '0;
            r_cpl_err      <= 1'b0;
            r_err_spurious <= 1'b0;
        end else begin
            r_cpl_valid    <= w_cpl_fire;
            r_cpl_txnid    <= w_cpl_fire ? w_cpl_idx : '0;
            r_cpl_write    <= w_cpl_fire && w_cpl_write;
            r_cpl_err      <= w_cpl_fire && w_cpl_err;
            r_cpl_rdata    <= (w_cpl_fire && !w_cpl_err && !w_cpl_write) ? i_rsp_rdata : '0;
            r_err_spurious <= w_spurious;
        end
    end

    assign o_req_valid    = r_req_valid;
    assign o_req_opcode   = r_req_opcode;
    assign o_req_addr     = r_req_addr;
    assign o_req_wdata    = r_req_wdata;
    assign o_req_txnid    = r_req_txnid;
    assign o_cpl_valid    = r_cpl_valid;
    assign o_cpl_txnid    = r_cpl_txnid;
    assign o_cpl_write    = r_cpl_write;
    assign o_cpl_rdata    = r_cpl_rdata;
    assign o_cpl_err      = r_cpl_err;
    assign o_err_spurious = r_err_spurious;

endmodule
